// File: rtl/md5_block_core_if.sv
// md5_block_core_if: block/chain input and digest output handshakes of the MD5 core
interface md5_block_core_if #(parameter int WORD_BITS = 32);
  logic                    i_valid;
  logic                    i_ready;
  logic [16*WORD_BITS-1:0] i_block;
  logic [WORD_BITS-1:0]    i_a, i_b, i_c, i_d;
  logic                    o_valid;
  logic                    o_ready;
  logic [WORD_BITS-1:0]    o_a, o_b, o_c, o_d;
  modport master (output i_valid, i_block, i_a, i_b, i_c, i_d, o_ready,
                  input  i_ready, o_valid, o_a, o_b, o_c, o_d);
  modport slave  (input  i_valid, i_block, i_a, i_b, i_c, i_d, o_ready,
                  output i_ready, o_valid, o_a, o_b, o_c, o_d);
endinterface

// File: rtl/md5_block_core.sv
// md5_block_core: iterative MD5 compression of one 512-bit block, STEPS_PER_CYCLE steps per clock
module md5_block_core #(
  parameter int WORD_BITS       = 32,
  parameter int STEPS_PER_CYCLE = 1
) (
  input logic             clk,
  input logic             reset,
  md5_block_core_if.slave bus
);
  if (WORD_BITS != 32) begin : g_bad_width
    $error("md5_block_core: WORD_BITS must be 32");
  end
  if (STEPS_PER_CYCLE != 1 && STEPS_PER_CYCLE != 2 && STEPS_PER_CYCLE != 4) begin : g_bad_steps
    $error("md5_block_core: STEPS_PER_CYCLE must be 1, 2 or 4");
  end
  localparam logic [31:0] T [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee, 32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be, 32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa, 32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed, 32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c, 32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05, 32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039, 32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1, 32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391};
  // indexed by {round, step mod 4}
  localparam logic [4:0] SH [16] = '{5'd7, 5'd12, 5'd17, 5'd22, 5'd5, 5'd9, 5'd14, 5'd20,
                                     5'd4, 5'd11, 5'd16, 5'd23, 5'd6, 5'd10, 5'd15, 5'd21};
  localparam logic [6:0] S = 7'(STEPS_PER_CYCLE);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t        state, state_n;
  logic [31:0]   x [16];
  logic [31:0]   a, b, c, d, h0, h1, h2, h3;
  logic [6:0]    cnt, cnt_n;
  logic [127:0]  st;
  function automatic logic [31:0] rotl(input logic [31:0] v, input logic [4:0] s);
    logic [63:0] w;
    w = {v, v} << s;
    return w[63:32];
  endfunction
  function automatic logic [3:0] msg_idx(input logic [5:0] j);
    return j[5:4] == 2'd0 ? j[3:0] :
           j[5:4] == 2'd1 ? 4'(5 * j[3:0] + 1) :
           j[5:4] == 2'd2 ? 4'(3 * j[3:0] + 5) : 4'(7 * j[3:0]);
  endfunction
  function automatic logic [127:0] md5_step(input logic [127:0] w, input logic [5:0] j, input logic [31:0] xg);
    logic [31:0] wa, wb, wc, wd, f;
    {wa, wb, wc, wd} = w;
    f = j[5:4] == 2'd0 ? (wb & wc) | (~wb & wd) :
        j[5:4] == 2'd1 ? (wb & wd) | (wc & ~wd) :
        j[5:4] == 2'd2 ? wb ^ wc ^ wd : wc ^ (wb | ~wd);
    return {wd, wb + rotl(wa + f + xg + T[j], SH[{j[5:4], j[1:0]}]), wb, wc};
  endfunction
  // chain this cycle's steps combinationally from the working registers
  always_comb begin
    st = {a, b, c, d};
    for (int k = 0; k < STEPS_PER_CYCLE; k++)
      st = md5_step(st, cnt[5:0] + 6'(k), x[msg_idx(cnt[5:0] + 6'(k))]);
  end
  // sequencer next state; the counter's last RUN value is 64-S
  always_comb begin
    cnt_n = cnt + S;
    state_n = state;
    case (state)
      IDLE:    state_n = bus.i_valid ? RUN : IDLE;
      RUN:     state_n = cnt_n == 7'd64 ? DONE : RUN;
      DONE:    state_n = bus.o_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_n;
  // capture block and chain on accept, advance the working state while running
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      for (int k = 0; k < 16; k++) x[k] <= '0;
      {a, b, c, d, h0, h1, h2, h3} <= '0;
      cnt <= '0;
    end else if (state == IDLE && bus.i_valid) begin
      for (int k = 0; k < 16; k++) x[k] <= bus.i_block[32*k +: 32];
      {a, b, c, d} <= {bus.i_a, bus.i_b, bus.i_c, bus.i_d};
      {h0, h1, h2, h3} <= {bus.i_a, bus.i_b, bus.i_c, bus.i_d};
      cnt <= '0;
    end else if (state == RUN) begin
      {a, b, c, d} <= st;
      cnt <= cnt_n;
    end
  assign bus.i_ready = state == IDLE;
  assign bus.o_valid = state == DONE;
  assign bus.o_a = h0 + a;
  assign bus.o_b = h1 + b;
  assign bus.o_c = h2 + c;
  assign bus.o_d = h3 + d;
endmodule

// File: tb/tb_md5_block_core.sv
// tb_md5_block_core: scoreboard bench for the MD5 core at 1, 2 and 4 steps per cycle
module tb_md5_block_core;
  localparam logic [511:0] EMPTY_B = 512'h80;
  localparam logic [511:0] ABC_B   = (512'h18 << 448) | 512'h80636261;
  localparam logic [511:0] JUNK_B  = {16{32'hdeadbeef}};
  localparam logic [127:0] CHAIN   = 128'h67452301_efcdab89_98badcfe_10325476;
  localparam logic [127:0] EMPTY_D = 128'hd98c1dd4_04b2008f_980980e9_7e42f8ec;
  localparam logic [127:0] ABC_D   = 128'h98500190_b04fd23c_7d3f96d6_727fe128;
  logic         clk = 0;
  logic         rst_n = 0;
  logic [511:0] blk = '0;
  logic [127:0] exp_dig = '0;
  logic         iv [3];
  logic         ordy [3];
  logic         ir [3];
  logic         ov [3];
  logic [127:0] dig [3];
  logic [127:0] q [3][$];
  int           errors = 0;
  int           checks = 0;
  int           cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  for (genvar n = 0; n < 3; n++) begin : g
    md5_block_core_if bus ();
    md5_block_core #(.WORD_BITS(32), .STEPS_PER_CYCLE(1 << n)) dut (.clk(clk), .reset(rst_n), .bus(bus));
    assign bus.i_valid = iv[n];
    assign bus.i_block = blk;
    assign {bus.i_a, bus.i_b, bus.i_c, bus.i_d} = CHAIN;
    assign bus.o_ready = ordy[n];
    assign ir[n] = bus.i_ready;
    assign ov[n] = bus.o_valid;
    assign dig[n] = {bus.o_a, bus.o_b, bus.o_c, bus.o_d};
  end
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask
  // scoreboard: push on accept, pop and compare on digest handshake
  always @(negedge clk)
    for (int n = 0; n < 3; n++)
      if (!rst_n) q[n].delete();
      else begin
        if (ov[n] && ordy[n]) begin
          chk($sformatf("valid_with_pending_block_s%0d", 1 << n), 128'(q[n].size() != 0), 128'd1);
          if (q[n].size() != 0) chk($sformatf("digest_s%0d", 1 << n), dig[n], q[n].pop_front());
        end
        if (iv[n] && ir[n]) q[n].push_back(exp_dig);
      end
  task automatic send(input int n, input logic [511:0] b, input logic [127:0] e, input int lat);
    int c;
    blk = b;
    exp_dig = e;
    iv[n] = 1;
    c = 0;
    @(negedge clk);
    while (!ir[n] && c < 200) begin @(negedge clk); c++; end
    @(posedge clk); #1;
    iv[n] = 0;
    blk = JUNK_B;
    c = 0;
    while (!ov[n] && c < 200) begin @(posedge clk); #1; c++; end
    chk($sformatf("latency_s%0d", 1 << n), 128'(c), 128'(lat));
  endtask
  task automatic b2b(input int n, input int cnt);
    int c, t0;
    t0 = -1;
    iv[n] = 1;
    for (int k = 0; k < cnt; k++) begin
      blk = k % 2 == 1 ? EMPTY_B : ABC_B;
      exp_dig = k % 2 == 1 ? EMPTY_D : ABC_D;
      c = 0;
      @(negedge clk);
      while (!ir[n] && c < 200) begin @(negedge clk); c++; end
      if (t0 >= 0) chk($sformatf("period_s%0d", 1 << n), 128'(cyc + 1 - t0), 128'(64 / (1 << n) + 2));
      t0 = cyc + 1;
      @(posedge clk); #1;
      blk = JUNK_B ^ 512'(k);
      repeat (3) @(posedge clk);
      #1 blk = ~JUNK_B;
      c = 0;
      while (!ov[n] && c < 200) begin @(negedge clk); c++; end
      @(posedge clk); #1;
    end
    iv[n] = 0;
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    for (int n = 0; n < 3; n++) begin iv[n] = 0; ordy[n] = 1; end
    repeat (5) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk); #1;
    for (int n = 0; n < 3; n++) begin
      chk("reset_i_ready", 128'(ir[n]), 128'd1);
      chk("reset_o_valid", 128'(ov[n]), 128'd0);
      chk("reset_digest", dig[n], 128'd0);
    end
    send(0, EMPTY_B, EMPTY_D, 64);
    for (int n = 0; n < 3; n++) send(n, ABC_B, ABC_D, 64 >> n);
    ordy[0] = 0;
    send(0, ABC_B, ABC_D, 64);
    for (int k = 0; k < 10; k++) begin
      chk("hold_o_valid", 128'(ov[0]), 128'd1);
      chk("hold_i_ready", 128'(ir[0]), 128'd0);
      chk("hold_digest", dig[0], ABC_D);
      @(posedge clk); #1;
    end
    ordy[0] = 1;
    @(posedge clk); #1;
    chk("release_i_ready", 128'(ir[0]), 128'd1);
    chk("release_o_valid", 128'(ov[0]), 128'd0);
    blk = ABC_B;
    exp_dig = ABC_D;
    iv[0] = 1;
    @(posedge clk); #1;
    iv[0] = 0;
    repeat (20) @(posedge clk);
    #1 rst_n = 0;
    #1 chk("abort_i_ready", 128'(ir[0]), 128'd1);
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    chk("after_abort_i_ready", 128'(ir[0]), 128'd1);
    repeat (80) begin
      @(posedge clk); #1;
      if (ov[0]) chk("abort_no_o_valid", 128'(ov[0]), 128'd0);
    end
    chk("abort_o_valid_low", 128'(ov[0]), 128'd0);
    b2b(0, 3);
    b2b(2, 4);
    repeat (5) @(posedge clk);
    #1;
    for (int n = 0; n < 3; n++) chk($sformatf("drained_s%0d", 1 << n), 128'(q[n].size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/md5_block_core.md
# md5_block_core

Iterative MD5 compression unit: accepts one 512-bit message block plus a 128-bit chaining state, runs all 64 MD5 steps in place, and returns the feed-forward-added chaining state. It is the sequential successor of the single combinational step. It adds:
- an internal step sequencer, constant ROM and shift table;
- a configurable number of unrolled steps per clock;
- valid/ready handshakes on both sides.

It sits between the message padder/nonce generator and the digest comparator in the hash-search pipeline.

## Interface
- WORD_BITS, 32, word width. Only 32 is legal; elaboration error otherwise.
- STEPS_PER_CYCLE, 1, MD5 steps applied per RUN cycle. Legal values are 1, 2 and 4; elaboration error otherwise.

Ports:
- clk  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- i_valid  input  1  block and chaining inputs are valid.
- i_ready  output  1  core can accept a block; high only in IDLE.
- i_block  input  16*WORD_BITS  message words. X[k] = i_block[32k+31:32k], already little-endian word order.
- i_a, i_b, i_c, i_d  input  WORD_BITS each  incoming chaining state.
- o_valid  output  1  digest words valid.
- o_ready  input  1  downstream accepts the digest.
- o_a, o_b, o_c, o_d  output  WORD_BITS each  chaining state out: input chaining value + final working value.

## Operation
- States: IDLE, RUN, DONE. Reset forces IDLE.
- IDLE:
  - i_ready=1.
  - On i_valid && i_ready, register i_block into the X[0..15] array.
  - Copy i_a..i_d into the working regs A..D and into the saved chain H0..H3.
  - Clear the step counter i to 0; go to RUN.
- RUN: each cycle applies STEPS_PER_CYCLE consecutive steps i..i+S-1, chained combinationally. For step j:
  - Round r = j/16.
  - Function: F=(B&C)|(~B&D); G=(B&D)|(C&~D); H=B^C^D; I=C^(B|~D).
  - Message index g: j; (5j+1) mod 16; (3j+5) mod 16; (7j) mod 16.
  - T[j] = floor(2^32·|sin(j+1)|).
  - Shift s:
    - round 0: 7,12,17,22;
    - round 1: 5,9,14,20;
    - round 2: 4,11,16,23;
    - round 3: 6,10,15,21;
    - each list repeats cyclically by j mod 4.
  - Update: B' = B + rotl(A+f+X[g]+T[j], s); A'=D; C'=B; D'=C.
  - All additions are modulo 2^32, with carries discarded.
  - The counter advances by S. When it reaches 64 (7-bit counter, last value 64−S), the next state is DONE.
- DONE:
  - o_valid=1.
  - o_a=H0+A, o_b=H1+B, o_c=H2+C, o_d=H3+D, all modulo 2^32.
  - Outputs are held stable until o_valid && o_ready, then the core returns to IDLE.
- i_valid outside IDLE is ignored; no block is captured.
- i_block and i_a..i_d need not be held after the accept edge.
- An active reset in any state aborts the operation immediately. The block is discarded and no o_valid is produced.

## Timing
- Reset values:
  - state=IDLE, i_ready=1, o_valid=0.
  - o_a..o_d = 0; working, saved-chain and X registers = 0; counter = 0.
- Latency: accept edge E0 → o_valid high from edge E0+64/S, i.e. 64, 32 or 16 cycles.
- Handshake exit: DONE with o_ready high at edge E1 → IDLE after E1. The earliest next accept is edge E1+1.
- Minimum block period: 64/S + 2 cycles.
- o_ready high before DONE has no effect. o_valid never drops without a handshake, except on reset.
- i_ready and o_valid are decoded from registered state only. There is no combinational path from i_valid or o_ready.

## Test plan
- Reset check: hold reset low 5 cycles, then release → i_ready=1, o_valid=0, o_a..o_d=0. Assert reset mid-RUN → IDLE next cycle, and o_valid is never asserted for that block.
- Empty-string block, S=1, o_ready tied high:
  - Stimulus: X[0]=0x00000080, rest 0; chain 67452301/efcdab89/98badcfe/10325476.
  - Response: o_a..o_d = 0xd98c1dd4, 0x04b2008f, 0x980980e9, 0x7e42f8ec.
  - o_valid rises exactly 64 cycles after the accept edge.
- "abc" block, repeated for S=1, 2, 4:
  - Stimulus: X[0]=0x80636261, X[14]=0x00000018, rest 0; same chain.
  - Response: o_a..o_d = 0x98500190, 0xb04fd23c, 0x7d3f96d6, 0x727fe128.
  - Latency is 64, 32 and 16 cycles respectively.
- Backpressure: o_ready low for 10 cycles in DONE → outputs stable and o_valid held; i_ready=0 throughout. Raise o_ready → IDLE next cycle.
- i_valid held high continuously while the core is busy:
  - Only IDLE-cycle samples are captured.
  - Change i_block mid-RUN → digest unchanged.
  - Back-to-back blocks complete at a period of 64/S+2 cycles.
